// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 5-stage MIPS pipeline front end.
//               Holds the fetch-stage state encoding, the reset PC, the
//               bubble instruction and the sequential PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Fetch sequencer states. Explicit 2-bit encoding.
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,  // post-reset, no request outstanding
    FS_WAIT = 2'd1,  // request to pc_f outstanding
    FS_HOLD = 2'd2,  // fetched word parked while decode is stalled
    FS_DROP = 2'd3   // outstanding response belongs to a squashed path
  } fetchState_t;

  localparam logic [31:0] c_resetPc  = 32'h0000_0000;
  localparam logic [31:0] c_nopInstr = 32'h0000_0000;
  localparam logic [31:0] c_pcStep   = 32'd4;

  // Sequential successor; wraps modulo 2^32 and passes the low bits through.
  function automatic logic [31:0] pcNext(input logic [31:0] pc);
    return pc + c_pcStep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register (instruction, PC, PC+4, valid).
//               Priority: rst > flush > load > hold.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               flush               - load a bubble (NOP, valid=0)
//               load                - capture instrIn/pcIn/pcPlus4In, valid=1
//               instrIn/pcIn/pcPlus4In - incoming fetch packet
//               instr/pc/pcPlus4/valid - register contents seen by decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = c_nopInstr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pcPlus4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= 32'd0;
      r_pcPlus4 <= 32'd0;
      r_valid   <= 1'b0;
    end else if (flush) begin
      // Bubble keeps the stale PC fields; only instr/valid matter downstream.
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else if (load) begin
      r_instr   <= instrIn;
      r_pc      <= pcIn;
      r_pcPlus4 <= pcPlus4In;
      r_valid   <= 1'b1;
    end
  end

  assign instr   = r_instr;
  assign pc      = r_pc;
  assign pcPlus4 = r_pcPlus4;
  assign valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns pc_f, the instruction-memory
//               request handshake, a one-entry hold buffer used while decode
//               is stalled, the pending redirect target used while a stale
//               response is drained, and the IF/ID register.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               stall_f, stall_d      - hazard-unit stalls
//               pc_src_d, pc_branch_d - taken branch in ID and its target
//               jump_d, pc_jump_d     - jump in ID and its target (wins)
//               imem_req, imem_addr   - fetch request / address (= pc_f)
//               imem_ready, imem_rdata- memory accept and returned word
//               instr_d, pc_d, pc_plus4_d, valid_d - IF/ID contents
//               fetch_busy            - request outstanding without data
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_resetPc,
  parameter logic [31:0] NOP_INSTR = c_nopInstr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic        jump_d,
  input  logic [31:0] pc_jump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_busy
);

  fetchState_t r_state;
  logic        r_imemReq;
  logic [31:0] r_pcF;
  logic [31:0] r_pendPc;
  logic [31:0] r_holdInstr;
  logic [31:0] r_holdPc;

  logic        w_advance;
  logic        w_redirect;
  logic        w_handshake;
  logic [31:0] w_target;

  logic        w_idLoad;
  logic        w_idFlush;
  logic [31:0] w_idInstr;
  logic [31:0] w_idPc;

  // A stalled decode stage cannot act on its own branch, so redirects are
  // only honoured when stall_d is low. stall_f alone still blocks advance.
  assign w_advance   = !stall_f && !stall_d;
  assign w_redirect  = (pc_src_d || jump_d) && !stall_d;
  assign w_target    = jump_d ? pc_jump_d : pc_branch_d;
  assign w_handshake = r_imemReq && imem_ready;

  // IF/ID steering. Sources are either the live memory word or the hold
  // buffer; anything not loaded or flushed is held.
  always_comb begin
    w_idLoad  = 1'b0;
    w_idFlush = 1'b0;
    w_idInstr = imem_rdata;
    w_idPc    = r_pcF;
    case (r_state)
      FS_WAIT: begin
        if (w_redirect) begin
          w_idFlush = 1'b1;
        end else if (w_handshake) begin
          w_idLoad = w_advance;
        end else if (w_advance) begin
          w_idFlush = 1'b1;  // no data yet: decode gets a bubble
        end
      end
      FS_HOLD: begin
        if (w_redirect) begin
          w_idFlush = 1'b1;
        end else if (w_advance) begin
          w_idLoad  = 1'b1;
          w_idInstr = r_holdInstr;
          w_idPc    = r_holdPc;
        end
      end
      FS_DROP: begin
        // Nothing useful can reach decode until the squashed response drains.
        w_idFlush = w_redirect || w_advance;
      end
      default: begin
      end
    endcase
  end

  // Fetch sequencer, PC, hold buffer and pending target. imem_req is a
  // registered copy of (state is WAIT or DROP), so stalls never reach it
  // combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FS_IDLE;
      r_imemReq   <= 1'b0;
      r_pcF       <= RESET_PC;
      r_pendPc    <= RESET_PC;
      r_holdInstr <= NOP_INSTR;
      r_holdPc    <= RESET_PC;
    end else begin
      case (r_state)
        FS_IDLE: begin
          r_state   <= FS_WAIT;
          r_imemReq <= 1'b1;
        end
        FS_WAIT: begin
          if (w_handshake) begin
            if (w_redirect) begin
              r_pcF <= w_target;
            end else if (w_advance) begin
              r_pcF <= pcNext(r_pcF);
            end else begin
              r_holdInstr <= imem_rdata;
              r_holdPc    <= r_pcF;
              r_state     <= FS_HOLD;
              r_imemReq   <= 1'b0;
            end
          end else if (w_redirect) begin
            // Address must stay put until the outstanding beat completes.
            r_pendPc <= w_target;
            r_state  <= FS_DROP;
          end
        end
        FS_HOLD: begin
          if (w_redirect) begin
            r_pcF     <= w_target;
            r_state   <= FS_WAIT;
            r_imemReq <= 1'b1;
          end else if (w_advance) begin
            r_pcF     <= pcNext(r_holdPc);
            r_state   <= FS_WAIT;
            r_imemReq <= 1'b1;
          end
        end
        FS_DROP: begin
          if (w_handshake) begin
            // A redirect arriving on the draining beat is the newest target.
            r_pcF   <= w_redirect ? w_target : r_pendPc;
            r_state <= FS_WAIT;
          end else if (w_redirect) begin
            r_pendPc <= w_target;
          end
        end
        default: begin
          r_state   <= FS_IDLE;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifId (
    .clk       (clk),
    .rst       (rst),
    .flush     (w_idFlush),
    .load      (w_idLoad),
    .instrIn   (w_idInstr),
    .pcIn      (w_idPc),
    .pcPlus4In (pcNext(w_idPc)),
    .instr     (instr_d),
    .pc        (pc_d),
    .pcPlus4   (pc_plus4_d),
    .valid     (valid_d)
  );

  assign imem_req   = r_imemReq;
  assign imem_addr  = r_pcF;
  assign fetch_busy = r_imemReq && !imem_ready;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the 5-stage MIPS pipeline. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It consumes the hazard unit's StallF/StallD and the ID-stage redirect (FlushD = branch taken | jump). It produces the instruction, PC and PC+4 seen by decode, plus a busy flag that the hazard unit ORs into its stall terms.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, value loaded into IF/ID on flush or bubble

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- stall_f  in  1  StallF from hazard unit
- stall_d  in  1  StallD from hazard unit
- pc_src_d  in  1  branch taken in ID
- pc_branch_d  in  32  branch target
- jump_d  in  1  jump in ID
- pc_jump_d  in  32  jump target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc_f)
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction, valid when imem_req & imem_ready
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  request outstanding without data (imem_req & !imem_ready)

## Operation
- States: IDLE, WAIT, HOLD, DROP.
- Reset values: state IDLE, pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, imem_req=0.
- Derived signals:
  - advance = !stall_f & !stall_d.
  - redirect = (pc_src_d | jump_d) & !stall_d. If both branch and jump are set, jump wins.
  - target = jump_d ? pc_jump_d : pc_branch_d.
- Handshake: imem_req=1 in WAIT and DROP only. While imem_req=1 and imem_ready=0, imem_addr must hold steady.
- IDLE: go to WAIT next cycle.
- WAIT, handshake completes, redirect=1: discard imem_rdata. pc_f←target. IF/ID←NOP, valid_d=0. Stay in WAIT.
- WAIT, handshake completes, no redirect, advance=1: IF/ID←{imem_rdata, pc_f, pc_f+4}, valid_d=1. pc_f←pc_f+4. Stay in WAIT.
- WAIT, handshake completes, no redirect, advance=0: store {rdata, pc_f} in the hold buffer. IF/ID unchanged. Go to HOLD.
- WAIT, no handshake, redirect=1: latch target into pend_pc. IF/ID←NOP. Go to DROP.
- WAIT, no handshake, no redirect, advance=1: IF/ID←NOP, valid_d=0 (bubble).
- WAIT, no handshake, no redirect, advance=0: IF/ID unchanged.
- HOLD, redirect=1: drop the buffer. pc_f←target. IF/ID←NOP. Go to WAIT.
- HOLD, advance=1: IF/ID←buffer, pc_f←buffer pc+4. Go to WAIT.
- HOLD, otherwise: stay in HOLD.
- DROP: on handshake, discard data, pc_f←pend_pc, go to WAIT. Another redirect while in DROP overwrites pend_pc.
- Priority on IF/ID: rst > redirect (flush) > stall (hold) > load.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0. The low two address bits are passed through unchecked.
- stall_f=1 with stall_d=0 is treated as a stall (advance=0).

## Timing
- Zero-wait memory (imem_ready tied 1): one instruction per cycle. An instruction fetched at edge N appears on instr_d after edge N.
- First imem_req rises in the second cycle after rst deasserts. First valid_d follows one cycle after the first handshake.
- Redirect costs exactly one NOP in ID. The target request issues the cycle after the redirect, or after the DROP handshake completes.
- fetch_busy is combinational from state and imem_ready. There is no path from stall inputs to imem_req.
- rst asserted mid-request forces IDLE at the next edge. The pending response is abandoned; memory must tolerate imem_req falling.

## Structure
- Shared `cpu_pkg`: fetch state enum, NOP_INSTR, RESET_PC default, PC_STEP=4.
- One sub-module, `if_id_reg`: 32+32+32+1 register with load/flush/hold controls and synchronous reset to NOP. fetch_stage holds the FSM, PC, hold buffer and pend_pc.

## Test plan
- Reset then ready=1 with program at 0: instr_d sequence rdata@0, @4, @8 on consecutive cycles; pc_plus4_d = 4, 8, 12.
- ready=0 for 3 cycles at addr 8: imem_addr stays 8, fetch_busy=1 for 3 cycles, valid_d=0 bubbles, then the instruction at 8 loads.
- Handshake with stall_d=1 for 2 cycles: go to HOLD, req=0, IF/ID unchanged; on release instr@addr loads and the next req is addr+4.
- jump_d=1 with pc_jump_d=0x40 while a request is pending (ready=0): DROP; the stale rdata on the late ready is discarded; next imem_addr=0x40; exactly one NOP in ID.
- pc_src_d and jump_d asserted together with targets 0x80/0x40: the fetch goes to 0x40. Redirect with stall_d=1 is ignored.
- rst asserted during DROP: next cycle state IDLE, pc_f=RESET_PC, valid_d=0, imem_req=0.
